// File: rtl/sha256_msg_padder_if.sv
// Stream interface of the SHA-256 message padder: raw message words in, padded words out.
interface sha256_msg_padder_if;
  logic        IN_VALID;
  logic        IN_READY;
  logic [31:0] IN_DATA;
  logic        IN_LAST;
  logic [2:0]  IN_BYTES;
  logic        OUT_VALID;
  logic        OUT_READY;
  logic [31:0] OUT_DATA;
  logic [3:0]  OUT_IDX;
  logic        OUT_BLOCK_LAST;

  // Host / loader side.
  modport master (
    output IN_VALID, IN_DATA, IN_LAST, IN_BYTES, OUT_READY,
    input  IN_READY, OUT_VALID, OUT_DATA, OUT_IDX, OUT_BLOCK_LAST
  );

  // Padder side.
  modport slave (
    input  IN_VALID, IN_DATA, IN_LAST, IN_BYTES, OUT_READY,
    output IN_READY, OUT_VALID, OUT_DATA, OUT_IDX, OUT_BLOCK_LAST
  );
endinterface

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: turns a stream of big-endian message words into padded 512-bit
// blocks (marker byte, zero fill, 64-bit bit length), one 32-bit word per cycle.
module sha256_msg_padder #(
  parameter int unsigned LEN_W = 64
) (
  input  logic                CLK,
  input  logic                RESET,
  sha256_msg_padder_if.slave  bus,
  output logic                BUSY
);

  typedef enum logic [2:0] {StData, StMark, StPad, StLenHi, StLenLo} state_e;

  state_e           state_q, state_d;
  logic [3:0]       idx_q;     // index of the next word loaded into the output slot
  logic [LEN_W-1:0] cnt_q, cnt_d;
  logic [63:0]      bit_len;
  logic [2:0]       nbytes;
  logic [31:0]      word;
  logic             slot_free, in_fire, out_fire, load;

  assign slot_free    = !bus.OUT_VALID || bus.OUT_READY;
  assign bus.IN_READY = (state_q == StData) && slot_free;
  assign in_fire      = bus.IN_VALID && bus.IN_READY;
  assign out_fire     = bus.OUT_VALID && bus.OUT_READY;
  assign bit_len      = 64'(cnt_q) << 3;

  // Next word to load, whether to load it, and the state after it is loaded.
  always_comb begin
    nbytes  = (bus.IN_BYTES > 3'd4) ? 3'd4 : bus.IN_BYTES;
    cnt_d   = cnt_q + LEN_W'(bus.IN_LAST ? nbytes : 3'd4);
    word    = 32'h0;
    load    = 1'b0;
    state_d = state_q;
    unique case (state_q)
      StData: begin
        load = in_fire;
        word = bus.IN_DATA;
        if (bus.IN_LAST) begin
          case (nbytes)
            3'd0:    word = 32'h8000_0000;
            3'd1:    word = {bus.IN_DATA[31:24], 24'h80_0000};
            3'd2:    word = {bus.IN_DATA[31:16], 16'h8000};
            3'd3:    word = {bus.IN_DATA[31:8], 8'h80};
            default: word = bus.IN_DATA;
          endcase
          // The length pair must land on indices 14/15.
          if (nbytes == 3'd4)     state_d = StMark;
          else if (idx_q == 4'd13) state_d = StLenHi;
          else                    state_d = StPad;
        end
      end
      StMark: begin
        load    = slot_free;
        word    = 32'h8000_0000;
        state_d = (idx_q == 4'd13) ? StLenHi : StPad;
      end
      StPad: begin
        load = slot_free;
        if (idx_q == 4'd13) state_d = StLenHi;
      end
      StLenHi: begin
        load    = slot_free;
        word    = bit_len[63:32];
        state_d = StLenLo;
      end
      StLenLo: begin
        load    = slot_free;
        word    = bit_len[31:0];
        state_d = StData;
      end
      default: state_d = StData;
    endcase
  end

  // Registered output slot, state, word index, byte counter and busy flag.
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q            <= StData;
      idx_q              <= 4'd0;
      cnt_q              <= '0;
      BUSY               <= 1'b0;
      bus.OUT_VALID      <= 1'b0;
      bus.OUT_DATA       <= 32'h0;
      bus.OUT_IDX        <= 4'd0;
      bus.OUT_BLOCK_LAST <= 1'b0;
    end else begin
      if (load) begin
        state_q            <= state_d;
        idx_q              <= idx_q + 4'd1;
        bus.OUT_VALID      <= 1'b1;
        bus.OUT_DATA       <= word;
        bus.OUT_IDX        <= idx_q;
        bus.OUT_BLOCK_LAST <= (state_q == StLenLo);
      end else if (out_fire) begin
        bus.OUT_VALID <= 1'b0;
      end
      // Length is already captured in the LEN_LO word, so clear for the next message.
      if (in_fire) cnt_q <= cnt_d;
      else if (load && state_q == StLenLo) cnt_q <= '0;
      // A new message accepted in the same cycle as LEN_LO keeps BUSY high.
      if (in_fire) BUSY <= 1'b1;
      else if (out_fire && bus.OUT_BLOCK_LAST) BUSY <= 1'b0;
    end
  end

endmodule
